im_frame_ctrl: RTL

- Frame controller for the image-memory pixel datapath.
- Generates 640x480 VGA timing: pixel enable, pixel_x/pixel_y, hsync/vsync, visible flag.
- Owns the live ball/bar location registers consumed by the pixel compositor.
- Accepts CPU location updates through a req/ack handshake and holds them in shadow registers. Pending updates commit atomically at vertical-blank start, so a frame never shows a mix of old and new positions.

---
 rtl/im_frame_ctrl_if.sv | 11 +
 rtl/im_frame_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/im_frame_ctrl_if.sv
// CPU location-update handshake between the requester and im_frame_ctrl.
// The requester holds upd_req until it sees the one-cycle upd_ack pulse.
interface im_frame_ctrl_if;
    logic        upd_req;
    logic [1:0]  upd_obj;
    logic [19:0] upd_loc;
    logic        upd_ack;

    modport master (output upd_req, output upd_obj, output upd_loc, input upd_ack);
    modport slave  (input upd_req, input upd_obj, input upd_loc, output upd_ack);
endinterface

// File: rtl/im_frame_ctrl.sv
// VGA frame timing plus ball/bar location registers with a CPU update handshake.
// IM_FRAME_CTRL_TEARFREE_EN selects shadowed updates committed at vertical-blank start.
module im_frame_ctrl #(
    parameter int unsigned PIX_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    im_frame_ctrl_if.slave       upd,
    output logic [9:0]           pixel_x,
    output logic [9:0]           pixel_y,
    output logic                 visible,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 frame_start,
    output logic [19:0]          ball_loc,
    output logic [19:0]          barl_loc,
    output logic [19:0]          barr_loc,
    output logic [2:0]           pending
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    // Locations are {y, x}
    localparam logic [19:0] BALL_RST = {10'd240, 10'd320};
    localparam logic [19:0] BARL_RST = {10'd240, 10'd8};
    localparam logic [19:0] BARR_RST = {10'd240, 10'd631};

    typedef enum logic {
        S_IDLE,
        S_ACK
    } state_t;

    logic [DIV_W-1:0] div;
    logic             pix_en;
    logic [9:0]       h_next;
    logic [9:0]       v_next;
    logic             stall;
    logic             accept;
    state_t           state;
    state_t           state_next;

    assign pix_en = (div == DIV_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        h_next = pixel_x;
        v_next = pixel_y;
        if (pix_en) begin
            if (pixel_x == H_LAST) begin
                h_next = '0;
                v_next = (pixel_y == V_LAST) ? '0 : pixel_y + 10'd1;
            end else begin
                h_next = pixel_x + 10'd1;
            end
        end
    end

    // Sync/flag outputs are decoded from the next counter values so they
    // change on the same edge as pixel_x/pixel_y.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            visible     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_x     <= h_next;
            pixel_y     <= v_next;
            hsync       <= !((h_next >= HS_START) && (h_next < HS_END));
            vsync       <= !((v_next >= VS_START) && (v_next < VS_END));
            visible     <= (h_next < H_VIS) && (v_next < V_VIS);
            frame_start <= pix_en && (h_next == '0) && (v_next == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            S_IDLE: begin
                if (upd.upd_req && !stall) begin
                    accept     = 1'b1;
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign upd.upd_ack = (state == S_ACK);

`ifdef IM_FRAME_CTRL_TEARFREE_EN
    logic        commit;
    logic [19:0] ball_sh;
    logic [19:0] barl_sh;
    logic [19:0] barr_sh;

    // Edge on which the counters move to (0, V_VISIBLE): start of vertical blank.
    assign commit = pix_en && (pixel_x == H_LAST) && (pixel_y == 10'(V_VISIBLE - 1));
    assign stall  = commit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ball_sh  <= BALL_RST;
            barl_sh  <= BARL_RST;
            barr_sh  <= BARR_RST;
            ball_loc <= BALL_RST;
            barl_loc <= BARL_RST;
            barr_loc <= BARR_RST;
            pending  <= '0;
        end else if (commit) begin
            if (pending[0]) ball_loc <= ball_sh;
            if (pending[1]) barl_loc <= barl_sh;
            if (pending[2]) barr_loc <= barr_sh;
            pending <= '0;
        end else if (accept) begin
            case (upd.upd_obj)
                2'd0: begin
                    ball_sh    <= upd.upd_loc;
                    pending[0] <= 1'b1;
                end
                2'd1: begin
                    barl_sh    <= upd.upd_loc;
                    pending[1] <= 1'b1;
                end
                2'd2: begin
                    barr_sh    <= upd.upd_loc;
                    pending[2] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
`else
    assign stall   = 1'b0;
    assign pending = '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ball_loc <= BALL_RST;
            barl_loc <= BARL_RST;
            barr_loc <= BARR_RST;
        end else if (accept) begin
            case (upd.upd_obj)
                2'd0:    ball_loc <= upd.upd_loc;
                2'd1:    barl_loc <= upd.upd_loc;
                2'd2:    barr_loc <= upd.upd_loc;
                default: begin
                end
            endcase
        end
    end
`endif

endmodule
